// File: rtl/rsp_route_fifo.sv
// Response router: remembers granted source indices in order and steers each response beat to its requester.
// Latency: index usable for routing one cycle after push; beats pass combinationally (valid and ready, no register stage).
// Backpressure: idx_ready_o drops when Depth indices are outstanding; rsp_ready_o follows the head destination's ready, and is 0 when empty.
module rsp_route_fifo #(
  parameter  int NumOut    = 4,
  parameter  int DataWidth = 32,
  parameter  int Depth     = 8,
  localparam int IdxW      = (NumOut > 1) ? $clog2(NumOut) : 1,
  localparam int CntW      = $clog2(Depth) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 idx_valid_i,
  input  logic [IdxW-1:0]      idx_i,
  output logic                 idx_ready_o,
  input  logic                 rsp_valid_i,
  input  logic                 rsp_last_i,
  input  logic [DataWidth-1:0] rsp_data_i,
  output logic                 rsp_ready_o,
  output logic [NumOut-1:0]    rsp_valid_o,
  output logic                 rsp_last_o,
  output logic [DataWidth-1:0] rsp_data_o,
  input  logic [NumOut-1:0]    rsp_ready_i,
  output logic [CntW-1:0]      outstanding_o,
  output logic                 err_unexp_o
);

  localparam int PtrW = $clog2(Depth);

  logic [IdxW-1:0] mem [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic            err_q;
  logic [IdxW-1:0] head;
  logic            empty;
  logic            head_in_range;
  logic            push, pop;

  assign empty         = (cnt_q == '0);
  assign head          = mem[rptr_q];
  // Indices that name no destination are kept so the response still drains in order.
  assign head_in_range = ({1'b0, head} < (IdxW+1)'(NumOut));

  // Full check depends only on the counter, never on the response side.
  assign idx_ready_o   = (cnt_q != CntW'(Depth));
  assign push          = idx_valid_i && idx_ready_o;
  assign pop           = rsp_valid_i && rsp_ready_o && rsp_last_i;

  assign rsp_last_o    = rsp_last_i;
  assign rsp_data_o    = rsp_data_i;
  assign outstanding_o = cnt_q;
  assign err_unexp_o   = err_q;

  // Steer valid to the head destination and return that destination's ready.
  always_comb begin
    rsp_valid_o = '0;
    rsp_ready_o = 1'b0;
    if (!empty) begin
      if (NumOut == 1) begin
        rsp_valid_o[0] = rsp_valid_i;
        rsp_ready_o    = rsp_ready_i[0];
      end else if (head_in_range) begin
        for (int i = 0; i < NumOut; i++) begin
          if (head == IdxW'(i)) begin
            rsp_valid_o[i] = rsp_valid_i;
            rsp_ready_o    = rsp_ready_i[i];
          end
        end
      end else begin
        rsp_ready_o = 1'b1;
      end
    end
  end

  // Index storage; contents are don't-care while the slot is not counted.
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      mem[wptr_q] <= idx_i;
    end
  end

  // Pointers, occupancy and the sticky unexpected-response flag; flush wins over push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (rsp_valid_i && empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rsp_route_fifo.sv
// Bench for rsp_route_fifo: directed scenarios plus a randomised grant/response stream.
// Reference model is an in-order queue of granted indices.
// Inputs change 1 time unit after the rising edge; outputs are checked 2 units after it.
module tb_rsp_route_fifo;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        idx_valid_i = 1'b0;
  logic [1:0]  idx_i = '0;
  logic        idx_ready_o;
  logic        rsp_valid_i = 1'b0;
  logic        rsp_last_i = 1'b0;
  logic [31:0] rsp_data_i = '0;
  logic        rsp_ready_o;
  logic [3:0]  rsp_valid_o;
  logic        rsp_last_o;
  logic [31:0] rsp_data_o;
  logic [3:0]  rsp_ready_i = '0;
  logic [3:0]  outstanding_o;
  logic        err_unexp_o;

  int nvec = 0;
  int nerr = 0;

  int   mq[$];
  logic merr = 1'b0;

  always #5 clk_i = ~clk_i;

  rsp_route_fifo dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .idx_valid_i(idx_valid_i), .idx_i(idx_i), .idx_ready_o(idx_ready_o),
    .rsp_valid_i(rsp_valid_i), .rsp_last_i(rsp_last_i), .rsp_data_i(rsp_data_i),
    .rsp_ready_o(rsp_ready_o), .rsp_valid_o(rsp_valid_o), .rsp_last_o(rsp_last_o),
    .rsp_data_o(rsp_data_o), .rsp_ready_i(rsp_ready_i),
    .outstanding_o(outstanding_o), .err_unexp_o(err_unexp_o)
  );

  function automatic logic [3:0] m_vld(input logic vin);
    if (mq.size() == 0 || !vin) return 4'b0000;
    if (mq[0] < 4) return 4'b0001 << mq[0];
    return 4'b0000;
  endfunction

  function automatic logic m_rdy(input logic [3:0] rin);
    if (mq.size() == 0) return 1'b0;
    if (mq[0] < 4) return rin[mq[0]];
    return 1'b1;
  endfunction

  // Advance one clock and apply the same cycle's effect to the reference queue.
  task automatic tick();
    bit push, pop, fl, unexp;
    int pidx;
    fl    = flush_i;
    push  = idx_valid_i && (mq.size() != 8);
    pop   = rsp_valid_i && rsp_last_i && m_rdy(rsp_ready_i);
    unexp = rsp_valid_i && (mq.size() == 0);
    pidx  = int'(idx_i);
    @(posedge clk_i);
    #1;
    if (fl) begin
      mq.delete();
      merr = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(pidx);
      if (unexp) merr = 1'b1;
    end
  endtask

  task automatic idle();
    idx_valid_i = 1'b0; rsp_valid_i = 1'b0; rsp_last_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic do_flush();
    idle();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    rsp_valid_i = 1'b1; rsp_ready_i = 4'b1111;
    #1;
    mq.delete(); merr = 1'b0;
    nvec++; if (outstanding_o !== 4'd0) begin nerr++; $display("FAIL reset_cnt got %0d want 0", outstanding_o); end
    nvec++; if (idx_ready_o !== 1'b1) begin nerr++; $display("FAIL reset_idx_ready got %b want 1", idx_ready_o); end
    nvec++; if (rsp_ready_o !== 1'b0) begin nerr++; $display("FAIL reset_rsp_ready got %b want 0", rsp_ready_o); end
    nvec++; if (rsp_valid_o !== 4'b0000) begin nerr++; $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid_o); end
    nvec++; if (err_unexp_o !== 1'b0) begin nerr++; $display("FAIL reset_err got %b want 0", err_unexp_o); end
    @(posedge clk_i); #1;
    idle();
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic test_order();
    logic [3:0] exp_v [3];
    int pidx [3];
    exp_v[0] = 4'b0100; exp_v[1] = 4'b0001; exp_v[2] = 4'b1000;
    pidx[0] = 2; pidx[1] = 0; pidx[2] = 3;
    do_flush();
    rsp_ready_i = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      idx_valid_i = 1'b1; idx_i = 2'(pidx[i]);
      tick();
    end
    idx_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rsp_valid_i = 1'b1; rsp_last_i = 1'b1; rsp_data_i = $urandom;
      #1;
      nvec++; if (outstanding_o !== 4'(3 - i)) begin nerr++; $display("FAIL order_cnt[%0d] got %0d want %0d", i, outstanding_o, 3 - i); end
      nvec++; if (rsp_valid_o !== exp_v[i]) begin nerr++; $display("FAIL order_route[%0d] got %b want %b", i, rsp_valid_o, exp_v[i]); end
      nvec++; if (rsp_data_o !== rsp_data_i) begin nerr++; $display("FAIL order_data[%0d] got %h want %h", i, rsp_data_o, rsp_data_i); end
      tick();
    end
    idle();
    #1;
    nvec++; if (outstanding_o !== 4'd0) begin nerr++; $display("FAIL order_cnt_end got %0d want 0", outstanding_o); end
  endtask

  task automatic test_multibeat();
    logic rpat [5];
    int beats = 0;
    rpat[0] = 1; rpat[1] = 0; rpat[2] = 1; rpat[3] = 1; rpat[4] = 1;
    do_flush();
    idx_valid_i = 1'b1; idx_i = 2'd1;
    tick();
    idx_valid_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      rsp_valid_i = 1'b1;
      rsp_last_i  = (beats == 3);
      rsp_ready_i = rpat[c] ? 4'b1111 : 4'b1101;
      #1;
      nvec++; if (rsp_valid_o !== 4'b0010) begin nerr++; $display("FAIL mb_route[%0d] got %b want 0010", c, rsp_valid_o); end
      nvec++; if (rsp_ready_o !== rpat[c]) begin nerr++; $display("FAIL mb_ready[%0d] got %b want %b", c, rsp_ready_o, rpat[c]); end
      nvec++; if (outstanding_o !== 4'd1) begin nerr++; $display("FAIL mb_cnt[%0d] got %0d want 1", c, outstanding_o); end
      if (rpat[c]) beats++;
      tick();
    end
    idle();
    #1;
    nvec++; if (beats !== 4 || outstanding_o !== 4'd0) begin nerr++; $display("FAIL mb_pop beats %0d cnt %0d want 4 and 0", beats, outstanding_o); end
  endtask

  task automatic test_full_wrap();
    do_flush();
    rsp_ready_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      idx_valid_i = 1'b1; idx_i = 2'($urandom_range(0, 3));
      tick();
    end
    idx_valid_i = 1'b1; idx_i = 2'd3;
    #1;
    nvec++; if (idx_ready_o !== 1'b0 || outstanding_o !== 4'd8) begin nerr++; $display("FAIL full rdy %b cnt %0d want 0 and 8", idx_ready_o, outstanding_o); end
    tick();
    nvec++; if (outstanding_o !== 4'd8) begin nerr++; $display("FAIL full_hold cnt %0d want 8", outstanding_o); end
    rsp_valid_i = 1'b1; rsp_last_i = 1'b1;
    #1;
    nvec++; if (idx_ready_o !== 1'b0) begin nerr++; $display("FAIL full_nobypass rdy %b want 0", idx_ready_o); end
    tick();
    nvec++; if (outstanding_o !== 4'd7) begin nerr++; $display("FAIL full_pop cnt %0d want 7", outstanding_o); end
    rsp_valid_i = 1'b0;
    tick();
    nvec++; if (outstanding_o !== 4'd8) begin nerr++; $display("FAIL full_9th cnt %0d want 8", outstanding_o); end
    idx_valid_i = 1'b0; rsp_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    idx_valid_i = 1'b1; idx_i = 2'd2;
    #1;
    nvec++; if (outstanding_o !== 4'd5) begin nerr++; $display("FAIL pp_pre cnt %0d want 5", outstanding_o); end
    tick();
    nvec++; if (outstanding_o !== 4'd5) begin nerr++; $display("FAIL pp_same cnt %0d want 5", outstanding_o); end
    for (int c = 0; c < 20; c++) begin
      idx_valid_i = 1'($urandom_range(0, 1)); idx_i = 2'($urandom_range(0, 3));
      rsp_valid_i = 1'($urandom_range(0, 1));
      #1;
      nvec++;
      if (rsp_valid_o !== m_vld(rsp_valid_i) || outstanding_o !== 4'(mq.size())) begin
        nerr++; $display("FAIL wrap[%0d] vld %b cnt %0d want %b %0d", c, rsp_valid_o, outstanding_o, m_vld(rsp_valid_i), mq.size());
      end
      tick();
    end
    idle();
  endtask

  task automatic test_unexp();
    do_flush();
    rsp_valid_i = 1'b1; rsp_last_i = 1'b1; rsp_ready_i = 4'b1111;
    #1;
    nvec++; if (rsp_ready_o !== 1'b0 || rsp_valid_o !== 4'b0000) begin nerr++; $display("FAIL unexp_route rdy %b vld %b want 0 0000", rsp_ready_o, rsp_valid_o); end
    nvec++; if (err_unexp_o !== 1'b0) begin nerr++; $display("FAIL unexp_early got %b want 0", err_unexp_o); end
    tick();
    rsp_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      nvec++; if (err_unexp_o !== 1'b1) begin nerr++; $display("FAIL unexp_sticky[%0d] got %b want 1", i, err_unexp_o); end
      tick();
    end
    do_flush();
    nvec++; if (err_unexp_o !== 1'b0) begin nerr++; $display("FAIL unexp_clear got %b want 0", err_unexp_o); end
  endtask

  task automatic test_flush();
    do_flush();
    rsp_ready_i = 4'b1111;
    idx_valid_i = 1'b1; idx_i = 2'd0; tick();
    idx_i = 2'd1; tick();
    idx_valid_i = 1'b0;
    rsp_valid_i = 1'b1; rsp_last_i = 1'b0;
    tick();
    flush_i = 1'b1;
    tick();
    idle();
    #1;
    nvec++; if (outstanding_o !== 4'd0 || rsp_ready_o !== 1'b0) begin nerr++; $display("FAIL flush cnt %0d rdy %b want 0 0", outstanding_o, rsp_ready_o); end
    idx_valid_i = 1'b1; idx_i = 2'd3;
    tick();
    idx_valid_i = 1'b0; rsp_valid_i = 1'b1; rsp_last_i = 1'b1;
    #1;
    nvec++; if (rsp_valid_o !== 4'b1000) begin nerr++; $display("FAIL flush_newpush got %b want 1000", rsp_valid_o); end
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    do_flush();
    rsp_ready_i = 4'b1111;
    idx_valid_i = 1'b1; idx_i = 2'd2; tick();
    idx_valid_i = 1'b0; rsp_valid_i = 1'b1; rsp_last_i = 1'b0;
    tick();
    rst_ni = 1'b0;
    #1;
    mq.delete(); merr = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    #1;
    nvec++; if (rsp_valid_o !== 4'b0000 || rsp_ready_o !== 1'b0) begin nerr++; $display("FAIL rstmid vld %b rdy %b want 0000 0", rsp_valid_o, rsp_ready_o); end
    tick();
    idle();
    do_flush();
  endtask

  task automatic test_random();
    int grants [4];
    int done [4];
    int got_beats [4];
    int exp_beats [4];
    int rr = 3;
    int budget;
    logic [3:0] req;
    for (int d = 0; d < 4; d++) begin grants[d] = 0; done[d] = 0; got_beats[d] = 0; exp_beats[d] = 0; end
    do_flush();
    for (int c = 0; c < 600; c++) begin
      req = 4'($urandom);
      idx_valid_i = (req != 0) && ($urandom_range(0, 3) != 0);
      for (int k = 1; k <= 4; k++) begin
        if (req[(rr + k) % 4]) begin idx_i = 2'((rr + k) % 4); break; end
      end
      rsp_valid_i = 1'($urandom_range(0, 1)) && (mq.size() != 0);
      rsp_last_i  = ($urandom_range(0, 2) == 0);
      rsp_data_i  = $urandom;
      rsp_ready_i = 4'($urandom);
      #1;
      nvec++;
      if (rsp_valid_o !== m_vld(rsp_valid_i) || rsp_ready_o !== m_rdy(rsp_ready_i) ||
          idx_ready_o !== (mq.size() != 8) || outstanding_o !== 4'(mq.size()) ||
          err_unexp_o !== merr || rsp_data_o !== rsp_data_i || rsp_last_o !== rsp_last_i) begin
        nerr++;
        $display("FAIL rand[%0d] vld %b rdy %b irdy %b cnt %0d err %b want %b %b %b %0d %b", c,
                 rsp_valid_o, rsp_ready_o, idx_ready_o, outstanding_o, err_unexp_o,
                 m_vld(rsp_valid_i), m_rdy(rsp_ready_i), (mq.size() != 8), mq.size(), merr);
      end
      for (int d = 0; d < 4; d++) begin
        if (rsp_valid_o[d] && rsp_ready_i[d]) begin
          got_beats[d]++;
          if (rsp_last_o) done[d]++;
        end
      end
      if (rsp_valid_i && m_rdy(rsp_ready_i)) exp_beats[mq[0]]++;
      if (idx_valid_i && mq.size() != 8) begin grants[idx_i]++; rr = int'(idx_i); end
      tick();
    end
    idx_valid_i = 1'b0; rsp_valid_i = 1'b1; rsp_last_i = 1'b1; rsp_ready_i = 4'b1111;
    budget = 0;
    while (mq.size() != 0 && budget < 20) begin
      #1;
      for (int d = 0; d < 4; d++) if (rsp_valid_o[d] && rsp_ready_i[d]) begin got_beats[d]++; done[d]++; end
      exp_beats[mq[0]]++;
      tick();
      budget++;
    end
    idle();
    #1;
    nvec++; if (outstanding_o !== 4'd0) begin nerr++; $display("FAIL rand_drain cnt %0d want 0", outstanding_o); end
    for (int d = 0; d < 4; d++) begin
      nvec++;
      if (done[d] !== grants[d] || got_beats[d] !== exp_beats[d]) begin
        nerr++; $display("FAIL rand_score[%0d] rsp %0d beats %0d want %0d %0d", d, done[d], got_beats[d], grants[d], exp_beats[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_multibeat();
    test_full_wrap();
    test_unexp();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
